vector_writeback: RTL and testbench

Consumer end of the vector execute datapath. Accepts completed vector-execute results (4-lane vector result plus 36-bit scalar result) through a valid/ready handshake. Buffers them in a small in-order FIFO and retires each entry by writing the vector register file (per-lane enables) and/or the scalar register file (arbitrated port). Also reports pending-write hazards on vector destinations to issue logic.

---
 rtl/vector_writeback.sv | 134 +++++++++++++
 tb/tb_vector_writeback.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback.sv
// Retire stage for the vector execute pipe: an in-order result FIFO whose head
// writes the vector RF (per-lane) and/or the shared scalar RF port, plus hazard lookup.
module vector_writeback #(
    parameter int DEPTH   = 4,
    parameter int VADDR_W = 5,
    parameter int SADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0][31:0]           in_vdata,
    input  logic [35:0]                in_rdata,
    input  logic [VADDR_W-1:0]         in_vdst,
    input  logic [SADDR_W-1:0]         in_sdst,
    input  logic                       in_vwen,
    input  logic                       in_swen,
    input  logic [3:0]                 in_lane_mask,
    output logic                       vrf_we,
    output logic [VADDR_W-1:0]         vrf_addr,
    output logic [3:0][31:0]           vrf_wdata,
    output logic [3:0]                 vrf_lane_en,
    output logic                       srf_req,
    input  logic                       srf_grant,
    output logic [SADDR_W-1:0]         srf_addr,
    output logic [35:0]                srf_wdata,
    input  logic [VADDR_W-1:0]         hz_vaddr,
    output logic                       hz_hit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0][31:0]   vdata_q [DEPTH];
    logic [35:0]        rdata_q [DEPTH];
    logic [VADDR_W-1:0] vdst_q  [DEPTH];
    logic [SADDR_W-1:0] sdst_q  [DEPTH];
    logic [3:0]         mask_q  [DEPTH];
    logic [DEPTH-1:0]   vact_q;
    logic [DEPTH-1:0]   sact_q;
    logic [DEPTH-1:0]   valid_q;

    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               vdone_q;
    logic               sdone_q;

    logic head_valid;
    logic s_fire;
    logic v_ok;
    logic s_ok;
    logic push;
    logic pop;

    assign in_ready   = ~rst & (count_q != CNT_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign head_valid = valid_q[head_q];

    assign vrf_we = head_valid & vact_q[head_q] & ~vdone_q;
    assign srf_req = head_valid & sact_q[head_q] & ~sdone_q;
    assign s_fire = srf_req & srf_grant;

    // A part is finished if inactive, already done, or completing this cycle.
    assign v_ok = ~vact_q[head_q] | vdone_q | vrf_we;
    assign s_ok = ~sact_q[head_q] | sdone_q | s_fire;
    assign pop  = head_valid & v_ok & s_ok;

    assign vrf_addr    = vrf_we  ? vdst_q[head_q]  : '0;
    assign vrf_wdata   = vrf_we  ? vdata_q[head_q] : '0;
    assign vrf_lane_en = vrf_we  ? mask_q[head_q]  : '0;
    assign srf_addr    = srf_req ? sdst_q[head_q]  : '0;
    assign srf_wdata   = srf_req ? rdata_q[head_q] : '0;
    assign count       = count_q;

    // The head stops hazarding once its vector write has landed.
    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && vact_q[i] && (vdst_q[i] == hz_vaddr) &&
                !((PTR_W'(i) == head_q) && vdone_q))
                hz_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vdata_q[i] <= '0;
                rdata_q[i] <= '0;
                vdst_q[i]  <= '0;
                sdst_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
            vact_q  <= '0;
            sact_q  <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vdone_q <= 1'b0;
            sdone_q <= 1'b0;
        end else begin
            if (push) begin
                vdata_q[tail_q] <= in_vdata;
                rdata_q[tail_q] <= in_rdata;
                vdst_q[tail_q]  <= in_vdst;
                sdst_q[tail_q]  <= in_sdst;
                mask_q[tail_q]  <= in_lane_mask;
                vact_q[tail_q]  <= in_vwen & (in_lane_mask != 4'b0000);
                sact_q[tail_q]  <= in_swen;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
                vdone_q         <= 1'b0;
                sdone_q         <= 1'b0;
            end else begin
                if (vrf_we)
                    vdone_q <= 1'b1;
                if (s_fire)
                    sdone_q <= 1'b1;
            end
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vector_writeback.sv
// Scoreboard bench for vector_writeback: directed pushes queue the expected RF writes,
// and a negedge monitor matches every vrf/srf write strobe against those queues.
module tb_vector_writeback;

    localparam int DEPTH   = 4;
    localparam int VADDR_W = 5;
    localparam int SADDR_W = 5;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [VADDR_W-1:0] addr;
        logic [3:0][31:0]   data;
        logic [3:0]         lane;
    } vexp_t;

    typedef struct packed {
        logic [SADDR_W-1:0] addr;
        logic [35:0]        data;
    } sexp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [3:0][31:0]    in_vdata;
    logic [35:0]         in_rdata;
    logic [VADDR_W-1:0]  in_vdst;
    logic [SADDR_W-1:0]  in_sdst;
    logic                in_vwen;
    logic                in_swen;
    logic [3:0]          in_lane_mask;
    logic                vrf_we;
    logic [VADDR_W-1:0]  vrf_addr;
    logic [3:0][31:0]    vrf_wdata;
    logic [3:0]          vrf_lane_en;
    logic                srf_req;
    logic                srf_grant;
    logic [SADDR_W-1:0]  srf_addr;
    logic [35:0]         srf_wdata;
    logic [VADDR_W-1:0]  hz_vaddr;
    logic                hz_hit;
    logic [CNT_W-1:0]    count;

    vexp_t exp_v[$];
    sexp_t exp_s[$];
    int    checks   = 0;
    int    failures = 0;

    vector_writeback #(.DEPTH(DEPTH), .VADDR_W(VADDR_W), .SADDR_W(SADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vdata     (in_vdata),
        .in_rdata     (in_rdata),
        .in_vdst      (in_vdst),
        .in_sdst      (in_sdst),
        .in_vwen      (in_vwen),
        .in_swen      (in_swen),
        .in_lane_mask (in_lane_mask),
        .vrf_we       (vrf_we),
        .vrf_addr     (vrf_addr),
        .vrf_wdata    (vrf_wdata),
        .vrf_lane_en  (vrf_lane_en),
        .srf_req      (srf_req),
        .srf_grant    (srf_grant),
        .srf_addr     (srf_addr),
        .srf_wdata    (srf_wdata),
        .hz_vaddr     (hz_vaddr),
        .hz_hit       (hz_hit),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one result for a single cycle and queues the writes it should produce.
    task automatic applyStimulus(input logic [VADDR_W-1:0] vdst, input logic [SADDR_W-1:0] sdst,
                                 input logic [3:0][31:0] vdata, input logic [35:0] rdata,
                                 input logic vwen, input logic swen, input logic [3:0] mask);
        in_valid     = 1'b1;
        in_vdst      = vdst;
        in_sdst      = sdst;
        in_vdata     = vdata;
        in_rdata     = rdata;
        in_vwen      = vwen;
        in_swen      = swen;
        in_lane_mask = mask;
        if (vwen && mask != 4'b0000)
            exp_v.push_back('{addr: vdst, data: vdata, lane: mask});
        if (swen)
            exp_s.push_back('{addr: sdst, data: rdata});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (vrf_we) begin
            if (exp_v.size() == 0) begin
                checkOutput("vrf_unexpected_write", 128'(1), 128'(0));
            end else begin
                vexp_t e;
                e = exp_v.pop_front();
                checkOutput("vrf_addr", 128'(vrf_addr), 128'(e.addr));
                checkOutput("vrf_wdata", 128'(vrf_wdata), 128'(e.data));
                checkOutput("vrf_lane_en", 128'(vrf_lane_en), 128'(e.lane));
            end
        end
        if (srf_req && srf_grant) begin
            if (exp_s.size() == 0) begin
                checkOutput("srf_unexpected_write", 128'(1), 128'(0));
            end else begin
                sexp_t e;
                e = exp_s.pop_front();
                checkOutput("srf_addr", 128'(srf_addr), 128'(e.addr));
                checkOutput("srf_wdata", 128'(srf_wdata), 128'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vdata = '0; in_rdata = '0; in_vdst = '0;
        in_sdst = '0; in_vwen = 1'b0; in_swen = 1'b0; in_lane_mask = '0;
        srf_grant = 1'b0; hz_vaddr = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_count", 128'(count), 128'(0));
        checkOutput("rst_vrf_we", 128'(vrf_we), 128'(0));
        checkOutput("rst_srf_req", 128'(srf_req), 128'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("post_rst_count", 128'(count), 128'(0));

        // Single vector-only push: write and retire one cycle after capture
        hz_vaddr = 5'd3;
        applyStimulus(5'd3, 5'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 36'h0, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        checkOutput("t1_vrf_we", 128'(vrf_we), 128'(1));
        checkOutput("t1_count", 128'(count), 128'(1));
        checkOutput("t1_hz_hit", 128'(hz_hit), 128'(1));
        @(negedge clk);
        checkOutput("t1_vrf_we_after", 128'(vrf_we), 128'(0));
        checkOutput("t1_count_after", 128'(count), 128'(0));
        checkOutput("t1_hz_hit_after", 128'(hz_hit), 128'(0));

        // Scalar push stalled three cycles, granted on the fourth
        applyStimulus(5'd0, 5'd7, '0, 36'h5_DEADBEEF, 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_srf_req_stall", 128'(srf_req), 128'(1));
            checkOutput("t2_count_stall", 128'(count), 128'(1));
        end
        @(posedge clk); #1; srf_grant = 1'b1;
        @(negedge clk);
        checkOutput("t2_srf_req_grant", 128'(srf_req), 128'(1));
        @(posedge clk); #1; srf_grant = 1'b0;
        @(negedge clk);
        checkOutput("t2_count_done", 128'(count), 128'(0));
        checkOutput("t2_srf_req_done", 128'(srf_req), 128'(0));

        // Fill to DEPTH with stalled scalar entries; fifth push must be refused
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(5'd0, SADDR_W'(10 + i), '0, 36'(36'h1_0000_0000 + i * 36'h111), 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        checkOutput("t3_count_full", 128'(count), 128'(4));
        checkOutput("t3_in_ready_full", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b1; in_swen = 1'b1; in_sdst = 5'd20; in_rdata = 36'hF_FFFF_FFFF;
        @(negedge clk);
        checkOutput("t3_in_ready_blocked", 128'(in_ready), 128'(0));
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t3_count_not_captured", 128'(count), 128'(4));
        @(posedge clk); #1; srf_grant = 1'b1;
        @(posedge clk); #1; srf_grant = 1'b0;
        @(negedge clk);
        checkOutput("t3_count_after_one", 128'(count), 128'(3));
        checkOutput("t3_in_ready_after_one", 128'(in_ready), 128'(1));
        @(posedge clk); #1; srf_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1; srf_grant = 1'b0;
        @(negedge clk);
        checkOutput("t3_count_drained", 128'(count), 128'(0));

        // Vector + scalar entry: single vector pulse, retire on delayed grant
        hz_vaddr = 5'd9;
        applyStimulus(5'd9, 5'd2, {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000},
                      36'hA_1234_5678, 1'b1, 1'b1, 4'b0101);
        @(negedge clk);
        checkOutput("t4_vrf_we_first", 128'(vrf_we), 128'(1));
        checkOutput("t4_srf_req_first", 128'(srf_req), 128'(1));
        checkOutput("t4_hz_hit_first", 128'(hz_hit), 128'(1));
        @(negedge clk);
        checkOutput("t4_vrf_we_second", 128'(vrf_we), 128'(0));
        checkOutput("t4_hz_hit_second", 128'(hz_hit), 128'(0));
        checkOutput("t4_count_second", 128'(count), 128'(1));
        @(posedge clk); #1; srf_grant = 1'b1;
        @(negedge clk);
        checkOutput("t4_vrf_we_grant", 128'(vrf_we), 128'(0));
        @(posedge clk); #1; srf_grant = 1'b0;
        @(negedge clk);
        checkOutput("t4_count_done", 128'(count), 128'(0));

        // Mask-zero vector entry: no strobe, no hazard, one-cycle retire
        hz_vaddr = 5'd17;
        applyStimulus(5'd17, 5'd0, {32'd9, 32'd9, 32'd9, 32'd9}, 36'h0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("t5_vrf_we", 128'(vrf_we), 128'(0));
        checkOutput("t5_hz_hit", 128'(hz_hit), 128'(0));
        checkOutput("t5_count", 128'(count), 128'(1));
        @(negedge clk);
        checkOutput("t5_count_after", 128'(count), 128'(0));

        // Back-to-back vector pushes drain at one per cycle
        applyStimulus(5'd1, 5'd0, {32'd11, 32'd12, 32'd13, 32'd14}, 36'h0, 1'b1, 1'b0, 4'b1000);
        applyStimulus(5'd2, 5'd0, {32'd21, 32'd22, 32'd23, 32'd24}, 36'h0, 1'b1, 1'b0, 4'b0011);
        applyStimulus(5'd4, 5'd0, {32'd31, 32'd32, 32'd33, 32'd34}, 36'h0, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        checkOutput("t6_count_stream", 128'(count), 128'(1));
        @(negedge clk);
        checkOutput("t6_count_drained", 128'(count), 128'(0));

        // Reset with three stalled scalar entries discards them
        for (int i = 0; i < 3; i++)
            applyStimulus(5'd0, SADDR_W'(24 + i), '0, 36'(36'h3_0000_0000 + i), 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        checkOutput("t7_count_queued", 128'(count), 128'(3));
        @(posedge clk); #1; rst = 1'b1;
        #1;
        checkOutput("t7_count_rst", 128'(count), 128'(0));
        checkOutput("t7_srf_req_rst", 128'(srf_req), 128'(0));
        checkOutput("t7_vrf_we_rst", 128'(vrf_we), 128'(0));
        exp_s.delete();
        @(posedge clk); #1; rst = 1'b0; srf_grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t7_srf_req_after", 128'(srf_req), 128'(0));
            checkOutput("t7_count_after", 128'(count), 128'(0));
        end
        srf_grant = 1'b0;

        checkOutput("scoreboard_vrf_pending", 128'(exp_v.size()), 128'(0));
        checkOutput("scoreboard_srf_pending", 128'(exp_s.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
